// File: rtl/instruction_fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage: FSM states,
// redirect controls from decode and the boot/timeout defaults.
package instruction_fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
  localparam int unsigned DEFAULT_TIMEOUT  = 255;

  typedef enum logic [1:0] {
    FS_BOOT,
    FS_FETCH,
    FS_VALID,
    FS_HALT
  } fetch_state_t;

  // Redirect requests from decode, highest priority first.
  typedef struct packed {
    logic jump_reg;
    logic jump;
    logic branch;
  } redirect_t;

  function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
    return addr_lsbs != 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory request/acknowledge bus between fetch (master) and
// instruction memory (slave).
interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instruction_fetch_next_pc_calc.sv
// Combinational next-PC selection for a retiring instruction: jr/jalr, j/jal,
// taken branch or sequential, plus an alignment flag on the chosen target.
module instruction_fetch_next_pc_calc
  import instruction_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] target,
  input  logic [31:0] rs_data,
  input  redirect_t   redirect,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] pc4;
  logic [31:0] branch_off;

  assign pc4        = pc + 32'd4;
  assign branch_off = {{14{target[15]}}, target[15:0], 2'b00};

  // NOTE: next_pc gets a default before the priority chain so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_pc = pc4;
    if (redirect.jump_reg) begin
      next_pc = rs_data;
    end else if (redirect.jump) begin
      next_pc = {pc4[31:28], target, 2'b00};
    end else if (redirect.branch) begin
      next_pc = pc4 + branch_off;
    end
  end

  assign misaligned = is_misaligned(next_pc[1:0]);

endmodule

// File: rtl/instruction_fetch.sv
// Multi-cycle fetch stage: owns the PC, fetches over a req/ack bus, holds the
// instruction for decode, applies redirects and counts retired instructions.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT  = DEFAULT_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                branch_en,
  input  logic                jump_en,
  input  logic                jump_reg_en,
  input  logic [31:0]         rs_data,
  instruction_fetch_if.master imem,
  output logic [31:0]         pc,
  output logic [31:0]         instr,
  output logic                instr_valid,
  output logic                fetch_fault,
  output logic [31:0]         retire_count
);

  localparam int               TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  fetch_state_t     state;
  logic [TMO_W-1:0] tmo;
  redirect_t        redirect;
  logic [31:0]      next_pc;
  logic             misaligned;

  assign redirect = '{jump_reg: jump_reg_en, jump: jump_en, branch: branch_en};

  instruction_fetch_next_pc_calc u_next_pc (
    .pc         (pc),
    .target     (instr[25:0]),
    .rs_data    (rs_data),
    .redirect   (redirect),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  // Decoded straight from the state register so reset drops the request at once.
  assign imem.imem_req  = (state == FS_FETCH);
  assign imem.imem_addr = pc;
  assign instr_valid    = (state == FS_VALID);

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FS_BOOT;
      pc           <= RESET_PC;
      instr        <= '0;
      fetch_fault  <= 1'b0;
      retire_count <= '0;
      tmo          <= '0;
    end else begin
      case (state)
        FS_BOOT: state <= FS_FETCH;

        FS_FETCH: begin
          if (imem.imem_ack) begin
            instr <= imem.imem_rdata;
            tmo   <= '0;
            state <= FS_VALID;
          end else if (tmo == TMO_LAST) begin
            fetch_fault <= 1'b1;
            state       <= FS_HALT;
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
        end

        FS_VALID: begin
          if (!stall) begin
            retire_count <= retire_count + 32'd1;
            // A misaligned target still retires the current instruction.
            if (misaligned) begin
              fetch_fault <= 1'b1;
              state       <= FS_HALT;
            end else begin
              pc    <= next_pc;
              state <= FS_FETCH;
            end
          end
        end

        FS_HALT: state <= FS_HALT;

        default: state <= FS_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a random
// phase, all compared against an instruction-level reference model.
module tb_instruction_fetch;

  localparam logic [31:0] BOOT_PC   = 32'h0040_0000;
  localparam int          TMO_LIMIT = 255;

  logic        clk         = 1'b0;
  logic        rst_n       = 1'b1;
  logic        stall       = 1'b0;
  logic        branch_en   = 1'b0;
  logic        jump_en     = 1'b0;
  logic        jump_reg_en = 1'b0;
  logic [31:0] rs_data     = 32'h0;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] retire_count;
  logic        instr_valid;
  logic        fetch_fault;

  instruction_fetch_if imem_bus ();

  instruction_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_en    (branch_en),
    .jump_en      (jump_en),
    .jump_reg_en  (jump_reg_en),
    .rs_data      (rs_data),
    .imem         (imem_bus),
    .pc           (pc),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .fetch_fault  (fetch_fault),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instruction memory contents, filled lazily with random words.
  logic [31:0] mem [logic [31:0]];

  // Reference model: architectural PC, retired count, fault and no-ack run length.
  logic [31:0] m_pc    = BOOT_PC;
  logic [31:0] m_count = 32'h0;
  bit          m_fault = 1'b0;
  int          m_tmo   = 0;
  bit          last_req   = 1'b0;
  bit          last_valid = 1'b0;

  // Memory responder configuration: lat_cfg < 0 draws a random 0..3 wait.
  int lat_cfg   = 0;
  int lat_left  = 0;
  bit in_fetch  = 1'b0;
  bit junk_ack  = 1'b0;
  bit rand_ctl  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  // Architectural next PC for the instruction word w at address cur.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] w);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    if (jump_reg_en) return rs_data;
    if (jump_en) return (seq & 32'hF000_0000) | ({6'b0, w[25:0]} << 2);
    if (branch_en) begin
      off = int'($signed(w[15:0]));
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  task automatic respond();
    if (imem_bus.imem_req) begin
      if (!in_fetch) begin
        in_fetch = 1'b1;
        lat_left = (lat_cfg < 0) ? int'($urandom_range(3, 0)) : lat_cfg;
      end
      if (lat_left == 0) begin
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);
        in_fetch            = 1'b0;
      end else begin
        lat_left--;
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = $urandom;
      end
    end else begin
      in_fetch            = 1'b0;
      imem_bus.imem_ack   = junk_ack ? 1'($urandom_range(1, 0)) : 1'b0;
      imem_bus.imem_rdata = $urandom;
    end
  endtask

  task automatic randomize_ctl();
    logic [31:0] v;
    stall       = ($urandom_range(99, 0) < 30);
    jump_reg_en = ($urandom_range(99, 0) < 6);
    jump_en     = ($urandom_range(99, 0) < 20);
    branch_en   = ($urandom_range(99, 0) < 25);
    v = $urandom;
    case ($urandom_range(19, 0))
      0:       rs_data = v;
      1:       rs_data = 32'hFFFF_FFFC;
      default: rs_data = BOOT_PC | (v & 32'h000F_FFFC);
    endcase
  endtask

  // One clock: advance the model over the coming edge, then compare.
  task automatic step();
    logic [31:0] nxt;
    bit          exp_req;
    bit          exp_valid;
    exp_req   = 1'b0;
    exp_valid = 1'b0;
    if (rst_n && !m_fault) begin
      if (last_valid) begin
        if (stall) begin
          exp_valid = 1'b1;
        end else begin
          m_count = m_count + 32'd1;
          nxt = ref_next(m_pc, mem_word(m_pc));
          if (nxt[1:0] != 2'b00) begin
            m_fault = 1'b1;
          end else begin
            m_pc    = nxt;
            exp_req = 1'b1;
          end
        end
      end else if (last_req) begin
        if (imem_bus.imem_ack) begin
          m_tmo     = 0;
          exp_valid = 1'b1;
        end else begin
          m_tmo++;
          if (m_tmo == TMO_LIMIT) m_fault = 1'b1;
          else exp_req = 1'b1;
        end
      end else begin
        exp_req = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check("fetch_fault", 32'(fetch_fault), 32'(m_fault));
    check("retire_count", retire_count, m_count);
    check("pc", pc, m_pc);
    check("imem_req", 32'(imem_bus.imem_req), 32'(exp_req));
    check("instr_valid", 32'(instr_valid), 32'(exp_valid));
    if (imem_bus.imem_req) check("imem_addr", imem_bus.imem_addr, m_pc);
    if (instr_valid) check("instr", instr, mem_word(m_pc));
    last_req   = imem_bus.imem_req;
    last_valid = instr_valid;
    respond();
    if (rand_ctl) randomize_ctl();
  endtask

  task automatic reset_dut();
    rst_n   = 1'b0;
    m_pc    = BOOT_PC;
    m_count = 32'h0;
    m_fault = 1'b0;
    m_tmo   = 0;
    #1;
    check("rst_imem_req", 32'(imem_bus.imem_req), 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'h0);
    check("rst_pc", pc, BOOT_PC);
    check("rst_instr", instr, 32'h0);
    check("rst_retire", retire_count, 32'h0);
    check("rst_fault", 32'(fetch_fault), 32'h0);
    last_req   = 1'b0;
    last_valid = 1'b0;
    step();
    step();
    // Stale acknowledge presented while leaving BOOT must be ignored.
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = 32'hDEAD_BEEF;
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 50 && !instr_valid; i++) step();
    check(tag, 32'(instr_valid), 32'h1);
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 50 && !imem_bus.imem_req; i++) step();
    check(tag, 32'(imem_bus.imem_req), 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t expected finish before 1000000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 32'h0;
    #2;

    // Sequential fetch with zero-wait memory: one instruction per two cycles.
    mem.delete();
    mem[32'h0040_0010] = 32'h1000_FFFF;
    lat_cfg = 0;
    reset_dut();
    step();
    check("t1_req0", 32'(imem_bus.imem_req), 32'h1);
    check("t1_addr0", imem_bus.imem_addr, 32'h0040_0000);
    step(); step();
    check("t1_addr1", imem_bus.imem_addr, 32'h0040_0004);
    step(); step();
    check("t1_addr2", imem_bus.imem_addr, 32'h0040_0008);
    step(); step();
    check("t1_retire3", retire_count, 32'd3);

    // beq -1 at 0x00400010: taken loops on itself, not taken falls through.
    wait_valid("t2_v0");
    step();
    wait_valid("t2_v1");
    check("t2_pc", pc, 32'h0040_0010);
    check("t2_instr", instr, 32'h1000_FFFF);
    branch_en = 1'b1;
    wait_req("t2_r0");
    check("t2_taken", imem_bus.imem_addr, 32'h0040_0010);
    branch_en = 1'b0;
    wait_valid("t2_v2");
    wait_req("t2_r1");
    check("t2_not_taken", imem_bus.imem_addr, 32'h0040_0014);

    // j target, then jr winning over a simultaneous j.
    mem.delete();
    mem[BOOT_PC] = 32'h0810_0040;
    reset_dut();
    wait_valid("t3_v0");
    jump_en = 1'b1;
    wait_req("t3_r0");
    check("t3_j_target", imem_bus.imem_addr, 32'h0040_0100);
    jump_reg_en = 1'b1;
    rs_data     = 32'h0040_0200;
    wait_valid("t3_v1");
    wait_req("t3_r1");
    check("t3_jr_wins", imem_bus.imem_addr, 32'h0040_0200);
    jump_en     = 1'b0;
    jump_reg_en = 1'b0;

    // Three wait cycles on memory, then a four-cycle stall in VALID.
    mem.delete();
    mem[BOOT_PC] = 32'h2408_0005;
    lat_cfg  = 3;
    junk_ack = 1'b1;
    reset_dut();
    stall = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (imem_bus.imem_req) n++;
      if (instr_valid) break;
    end
    check("t4_req_cycles", 32'(n), 32'd4);
    check("t4_pc", pc, BOOT_PC);
    check("t4_instr", instr, 32'h2408_0005);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_stall_valid", 32'(instr_valid), 32'h1);
      check("t4_stall_pc", pc, BOOT_PC);
      check("t4_stall_instr", instr, 32'h2408_0005);
      check("t4_stall_retire", retire_count, 32'd0);
    end
    stall = 1'b0;
    step();
    check("t4_retire_once", retire_count, 32'd1);
    check("t4_next_req", 32'(imem_bus.imem_req), 32'h1);
    check("t4_next_addr", imem_bus.imem_addr, 32'h0040_0004);

    // Memory never answers: fault after exactly TIMEOUT fetch cycles.
    mem.delete();
    lat_cfg  = 1_000_000;
    junk_ack = 1'b0;
    reset_dut();
    n = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (!imem_bus.imem_req) break;
      n++;
    end
    check("t5_fetch_cycles", 32'(n), 32'd255);
    check("t5_fault", 32'(fetch_fault), 32'h1);
    check("t5_req_low", 32'(imem_bus.imem_req), 32'h0);
    junk_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5_halt_fault", 32'(fetch_fault), 32'h1);
      check("t5_halt_valid", 32'(instr_valid), 32'h0);
    end

    // Misaligned jr target: fault, PC kept, instruction still retired.
    lat_cfg  = 0;
    junk_ack = 1'b0;
    reset_dut();
    wait_valid("t5_v0");
    jump_reg_en = 1'b1;
    rs_data     = 32'h0040_0202;
    step();
    check("t5_jr_fault", 32'(fetch_fault), 32'h1);
    check("t5_jr_pc", pc, BOOT_PC);
    check("t5_jr_retire", retire_count, 32'd1);
    check("t5_jr_req", 32'(imem_bus.imem_req), 32'h0);
    jump_reg_en = 1'b0;
    step(); step();

    // PC wrap at the top of memory, then reset in the middle of a fetch.
    mem.delete();
    reset_dut();
    wait_valid("t6_v0");
    jump_reg_en = 1'b1;
    rs_data     = 32'hFFFF_FFFC;
    wait_req("t6_r0");
    check("t6_addr_top", imem_bus.imem_addr, 32'hFFFF_FFFC);
    jump_reg_en = 1'b0;
    lat_cfg = 1_000_000;
    wait_valid("t6_v1");
    wait_req("t6_r1");
    check("t6_addr_wrap", imem_bus.imem_addr, 32'h0000_0000);
    step(); step();
    lat_cfg  = 2;
    junk_ack = 1'b1;
    reset_dut();
    step();
    check("t6_boot_addr", imem_bus.imem_addr, BOOT_PC);
    check("t6_no_valid", 32'(instr_valid), 32'h0);
    step();
    check("t6_still_fetch", 32'(imem_bus.imem_req), 32'h1);

    // Random redirects, stalls, memory waits and stray acknowledges.
    lat_cfg  = -1;
    junk_ack = 1'b1;
    rand_ctl = 1'b1;
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      step();
      if (m_fault && $urandom_range(3, 0) == 0) reset_dut();
      else if ($urandom_range(599, 0) == 0) reset_dut();
    end
    rand_ctl = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
